// File: rtl/smvm_row_encoder.sv
// -----------------------------------------------------------------------------
// smvm_row_encoder
//
// Front end of the sparse matrix-vector multiplier. It takes a dense matrix
// one signed 8-bit element per cycle in row-major order and drops the zeros.
// For every nonzero it emits a (value, column, ipv) entry; ipv=1 marks the
// last entry of a row. A row with no nonzeros still produces one (0, 0, 1)
// entry, so the consumer always sees exactly one ipv=1 per row.
// Entries are buffered in a first-word-fall-through FIFO. When the FIFO is
// full, backpressure from out_ready reaches the dense source through in_ready.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   MAX_COLS  maximum columns per row (column index is 3 bits)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      frame start pulse, sampled only while idle
//   num_rows   rows in the frame, latched on an accepted start
//   num_cols   columns per row (1..MAX_COLS), latched on an accepted start
//   in_valid   dense element valid
//   in_data    dense element, signed two's complement
//   in_ready   element accepted when in_valid & in_ready
//   out_valid  FIFO head valid
//   out_val    entry value (signed)
//   out_col    entry column index
//   out_ipv    1 = last entry of its row
//   out_ready  entry popped when out_valid & out_ready
//   busy       high whenever a frame is in progress
//   done       one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module smvm_row_encoder #(
    parameter int DEPTH    = 8,
    parameter int MAX_COLS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] num_rows,
    input  logic [3:0] num_cols,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_val,
    output logic [2:0] out_col,
    output logic       out_ipv,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        ROW_END = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t        state_reg;
    logic [7:0]    num_rows_reg;
    logic [3:0]    num_cols_reg;
    logic [2:0]    col_cnt_reg;
    logic [7:0]    row_cnt_reg;
    logic [7:0]    pend_val_reg;
    logic [2:0]    pend_col_reg;
    logic          pend_v_reg;
    logic          done_reg;

    // FIFO storage and bookkeeping
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          space;
    logic          accept;
    logic          in_nonzero;
    logic          last_col;
    logic          last_row;
    logic          push;
    logic [EW-1:0] push_data;
    logic          pop;
    logic [EW-1:0] head;

    // Space is judged on the registered count only, so a pop in this cycle
    // does not open in_ready until the next one (no out_ready -> in_ready path).
    assign space      = (count_reg < CW'(DEPTH));
    assign in_ready   = (state_reg == SCAN) && space;
    assign accept     = in_valid && in_ready;
    assign in_nonzero = (in_data != 8'd0);
    assign last_col   = ({1'b0, col_cnt_reg} == (num_cols_reg - 4'd1));
    assign last_row   = (row_cnt_reg == (num_rows_reg - 8'd1));

    // Entry generation. A nonzero is held in the pending register until we
    // know whether another nonzero follows in the same row; only then can its
    // ipv bit be decided. The final entry of a row is written in ROW_END.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state_reg == SCAN) begin
            if (accept && in_nonzero && pend_v_reg) begin
                push      = 1'b1;
                push_data = {pend_val_reg, pend_col_reg, 1'b0};
            end
        end else if (state_reg == ROW_END) begin
            if (space) begin
                push      = 1'b1;
                push_data = pend_v_reg ? {pend_val_reg, pend_col_reg, 1'b1}
                                       : {8'd0, 3'd0, 1'b1};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            num_rows_reg <= 8'd0;
            num_cols_reg <= 4'd0;
            col_cnt_reg  <= 3'd0;
            row_cnt_reg  <= 8'd0;
            pend_val_reg <= 8'd0;
            pend_col_reg <= 3'd0;
            pend_v_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if ((num_rows == 8'd0) || (num_cols == 4'd0)) begin
                            // Empty frame: nothing to scan, just complete.
                            state_reg <= DRAIN;
                        end else begin
                            num_rows_reg <= num_rows;
                            num_cols_reg <= num_cols;
                            col_cnt_reg  <= 3'd0;
                            row_cnt_reg  <= 8'd0;
                            pend_v_reg   <= 1'b0;
                            state_reg    <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    if (accept) begin
                        if (in_nonzero) begin
                            pend_val_reg <= in_data;
                            pend_col_reg <= col_cnt_reg;
                            pend_v_reg   <= 1'b1;
                        end
                        if (last_col) begin
                            col_cnt_reg <= 3'd0;
                            state_reg   <= ROW_END;
                        end else begin
                            col_cnt_reg <= col_cnt_reg + 3'd1;
                        end
                    end
                end

                ROW_END: begin
                    // Held here until the row-closing entry fits in the FIFO.
                    if (space) begin
                        pend_v_reg <= 1'b0;
                        if (last_row) begin
                            state_reg <= DRAIN;
                        end else begin
                            row_cnt_reg <= row_cnt_reg + 8'd1;
                            state_reg   <= SCAN;
                        end
                    end
                end

                DRAIN: begin
                    // Empty FIFO observed -> raise done next cycle, and leave
                    // DRAIN together with the done pulse so busy covers it.
                    if (done_reg) begin
                        state_reg <= IDLE;
                    end else if (count_reg == '0) begin
                        done_reg <= 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

    // -------------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // -------------------------------------------------------------------------
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The head is masked while the FIFO is empty so stale or uninitialised
    // storage never shows on the outputs (they read zero after reset).
    assign head    = mem[rd_ptr_reg];
    assign out_val = out_valid ? head[11:4] : 8'd0;
    assign out_col = out_valid ? head[3:1]  : 3'd0;
    assign out_ipv = out_valid ? head[0]    : 1'b0;

endmodule

// File: tb/tb_smvm_row_encoder.sv
// -----------------------------------------------------------------------------
// tb_smvm_row_encoder
//
// Directed and randomized frames for smvm_row_encoder. Expected entries come
// from a reference model that walks the dense matrix row by row: every
// nonzero becomes (value, column), the last nonzero of a row carries ipv=1,
// and a row without nonzeros yields a single (0, 0, 1).
// -----------------------------------------------------------------------------
module tb_smvm_row_encoder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] num_rows;
    logic [3:0] num_cols;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_val;
    logic [2:0] out_col;
    logic       out_ipv;
    logic       out_ready;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mat[$];
    logic [11:0] exp_q[$];

    smvm_row_encoder #(.DEPTH(8), .MAX_COLS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_val   (out_val),
        .out_col   (out_col),
        .out_ipv   (out_ipv),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected entry list for the matrix in mat.
    task automatic build_expected(input int nr, input int nc);
        exp_q.delete();
        for (int r = 0; r < nr; r++) begin
            int last_nz = -1;
            for (int c = 0; c < nc; c++)
                if (mat[r*nc + c] != 8'd0) last_nz = c;
            for (int c = 0; c < nc; c++) begin
                logic [7:0] v = mat[r*nc + c];
                if (v != 8'd0)
                    exp_q.push_back({v, 3'(c), (c == last_nz) ? 1'b1 : 1'b0});
            end
            if (last_nz < 0) exp_q.push_back({8'd0, 3'd0, 1'b1});
        end
    endtask

    task automatic random_matrix(input int nr, input int nc);
        mat.delete();
        for (int i = 0; i < nr*nc; i++)
            mat.push_back(($urandom_range(99) < 40) ? 8'd0 : 8'($urandom_range(1, 255)));
    endtask

    // Runs one frame over mat. hold>0 keeps out_ready low for that many cycles
    // and then checks the stalled state; restart_cyc>0 pulses a stray start.
    task automatic run_frame(input int nr, input int nc, input int hold, input int chk_idx,
                             input int restart_cyc, input int vld_pct, input int rdy_pct);
        int n = nr * nc;
        int idx = 0;
        int dones = 0;
        int cyc = 0;
        bit finished = 0;
        bit prev_stall = 0;
        logic [11:0] prev_out = '0;
        build_expected(nr, nc);
        @(negedge clk);
        start = 1'b1; num_rows = 8'(nr); num_cols = 4'(nc);
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc < 4000) begin
            if (done) dones++;
            if (dones > 0 && !done && !busy) begin
                finished = 1;
            end else begin
                if (hold > 0 && cyc == hold) begin
                    check("bp_accepted", 32'(idx), 32'(chk_idx));
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                end
                if (prev_stall)
                    check("stall_stable", {19'd0, out_valid, out_val, out_col, out_ipv},
                          {19'd0, 1'b1, prev_out});
                out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_with_empty_model", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("entry", {20'd0, out_val, out_col, out_ipv}, {20'd0, exp_q[0]});
                        $display("[TB] entry val=%0d col=%0d ipv=%0d exp val=%0d col=%0d ipv=%0d",
                                 $signed(out_val), out_col, out_ipv,
                                 $signed(exp_q[0][11:4]), exp_q[0][3:1], exp_q[0][0]);
                        void'(exp_q.pop_front());
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_val, out_col, out_ipv};
                in_valid = (idx < n) && ($urandom_range(99) < vld_pct);
                in_data  = (idx < n) ? mat[idx] : 8'($urandom);
                if (in_valid && in_ready) idx++;
                start    = (restart_cyc > 0) && (cyc == restart_cyc);
                num_cols = start ? 4'(nc == 2 ? 5 : 2) : 4'(nc);
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        check("frame_finished", 32'(finished), 32'd1);
        check("done_pulses", 32'(dones), 32'd1);
        check("entries_left", 32'(exp_q.size()), 32'd0);
        check("elements_accepted", 32'(idx), 32'(n));
        $display("[TB] frame rows=%0d cols=%0d cycles=%0d", nr, nc, cyc);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_rows = 8'd0; num_cols = 4'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", {26'd0, out_valid, out_val != 0, out_col != 0, out_ipv, busy, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Single row with mid-row zeros and a negative value
        mat = '{8'd0, 8'd3, 8'd0, 8'hFE};
        run_frame(1, 4, 0, 0, 0, 100, 100);

        // All-zero row followed by a dense row
        mat = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd6, 8'd7};
        run_frame(2, 3, 0, 0, 0, 100, 100);

        // Backpressure: 3x4 all nonzero, FIFO fills with 8 entries
        mat.delete();
        for (int i = 1; i <= 12; i++) mat.push_back(8'(i));
        run_frame(3, 4, 40, 8, 0, 100, 100);

        // Degenerate frame
        @(negedge clk);
        start = 1'b1; num_rows = 8'd0; num_cols = 4'd4;
        @(negedge clk);
        start = 1'b0;
        check("degen_c1_busy", 32'(busy), 32'd1);
        check("degen_c1_done", 32'(done), 32'd0);
        check("degen_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("degen_c2_busy", 32'(busy), 32'd1);
        check("degen_c2_done", 32'(done), 32'd1);
        @(negedge clk);
        check("degen_c3_busy", 32'(busy), 32'd0);
        check("degen_c3_done", 32'(done), 32'd0);
        $display("[TB] degenerate frame checked");

        // Reset in the middle of a row
        @(negedge clk);
        start = 1'b1; num_rows = 8'd1; num_cols = 4'd4;
        @(negedge clk);
        start = 1'b0;
        begin
            int fed = 0;
            int guard = 0;
            while (fed < 2 && guard < 50) begin
                in_valid = 1'b1;
                in_data  = 8'(fed + 9);
                if (in_ready) fed++;
                @(negedge clk);
                guard++;
            end
            check("midreset_fed", 32'(fed), 32'd2);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {24'd0, in_ready, out_valid, out_val != 0, out_col != 0, out_ipv, busy, done, 1'b0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        random_matrix(2, 5);
        run_frame(2, 5, 0, 0, 0, 90, 80);

        // Stray start while scanning must not change the frame
        random_matrix(3, 6);
        run_frame(3, 6, 0, 0, 3, 100, 100);

        // Randomized frames with random gaps and backpressure
        for (int f = 0; f < 8; f++) begin
            int nr = $urandom_range(1, 5);
            int nc = $urandom_range(1, 8);
            random_matrix(nr, nc);
            run_frame(nr, nc, 0, 0, 0, $urandom_range(50, 100), $urandom_range(20, 100));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
